// File: rtl/pc_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pc_ctrl_pkg                                                        |
// | Shared state encodings and redirect kinds for the PC write path.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } pc_state_t;

    localparam logic RD_JMP = 1'b0;
    localparam logic RD_BR  = 1'b1;

    localparam int unsigned INSTR_BYTES_DEF = 4;

endpackage
`default_nettype wire

// File: rtl/pc_redirect_buf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pc_redirect_buf                                                    |
// | Pending redirect held while the pipe is stalled.                   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pc_redirect_buf
    import pc_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             clr,
    input  logic             ld_br,
    input  logic             ld_jmp,
    input  logic [WIDTH-1:0] br_target,
    input  logic [WIDTH-1:0] jmp_target,
    output logic             pend_valid,
    output logic [WIDTH-1:0] pend_target
);

    logic             r_valid;
    logic             r_kind;
    logic [WIDTH-1:0] r_target;

    // A branch is older than any jump, so a jump may only replace a jump.
    always_ff @(posedge Clk) begin
        if (Rst || clr) begin
            r_valid  <= 1'b0;
            r_kind   <= RD_JMP;
            r_target <= '0;
        end else if (ld_br) begin
            r_valid  <= 1'b1;
            r_kind   <= RD_BR;
            r_target <= br_target;
        end else if (ld_jmp && (!r_valid || r_kind == RD_JMP)) begin
            r_valid  <= 1'b1;
            r_kind   <= RD_JMP;
            r_target <= jmp_target;
        end
    end

    assign pend_valid  = r_valid;
    assign pend_target = r_target;

endmodule
`default_nettype wire

// File: rtl/pc_write_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pc_write_ctrl                                                      |
// | Next-PC / PC-enable arbitration: fetch, redirects, stalls, boot.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pc_write_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int INSTR_BYTES = INSTR_BYTES_DEF,
    parameter int BOOT_WAIT   = 2,
    parameter int CNT_W       = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] Pc_Cur,
    input  logic             Stall,
    input  logic             Br_Taken,
    input  logic [WIDTH-1:0] Br_Target,
    input  logic             Jmp,
    input  logic [WIDTH-1:0] Jmp_Target,
    output logic [WIDTH-1:0] Pc_Next,
    output logic             Pc_En,
    output logic             Flush_IF,
    output logic             Fetch_Valid,
    output logic [CNT_W-1:0] Stall_Cnt
);

    localparam int        c_BW     = (BOOT_WAIT > 1) ? $clog2(BOOT_WAIT + 1) : 1;
    localparam pc_state_t c_RST_ST = (BOOT_WAIT == 0) ? ST_RUN : ST_BOOT;

    pc_state_t        r_state;
    pc_state_t        w_state_nxt;
    logic [c_BW-1:0]  r_boot_cnt;
    logic             r_fetch_valid;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [WIDTH-1:0] w_pc_inc;
    logic             w_ld_br;
    logic             w_ld_jmp;
    logic             w_clr;
    logic             w_pend_valid;
    logic [WIDTH-1:0] w_pend_target;

    assign w_pc_inc = Pc_Cur + WIDTH'(INSTR_BYTES);

    pc_redirect_buf #(
        .WIDTH (WIDTH)
    ) u_redirect_buf (
        .Clk         (Clk),
        .Rst         (Rst),
        .clr         (w_clr),
        .ld_br       (w_ld_br),
        .ld_jmp      (w_ld_jmp),
        .br_target   (Br_Target),
        .jmp_target  (Jmp_Target),
        .pend_valid  (w_pend_valid),
        .pend_target (w_pend_target)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= c_RST_ST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        Pc_Next     = w_pc_inc;
        Pc_En       = 1'b0;
        Flush_IF    = 1'b0;
        w_ld_br     = 1'b0;
        w_ld_jmp    = 1'b0;
        w_clr       = 1'b0;
        if (!Rst) begin
            case (r_state)
                ST_BOOT: begin
                    if (r_boot_cnt <= c_BW'(1)) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (Stall) begin
                        w_ld_br  = Br_Taken;
                        w_ld_jmp = Jmp;
                        if (Br_Taken || Jmp) begin
                            w_state_nxt = ST_HOLD;
                        end
                    end else begin
                        Pc_En = 1'b1;
                        if (Br_Taken) begin
                            Pc_Next  = Br_Target;
                            Flush_IF = 1'b1;
                        end else if (Jmp) begin
                            Pc_Next  = Jmp_Target;
                            Flush_IF = 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (Stall) begin
                        w_ld_br  = Br_Taken;
                        w_ld_jmp = Jmp;
                    end else begin
                        // A fresh branch is older than the pending entry; a fresh
                        // jump is younger and dies in the flush.
                        Pc_En       = 1'b1;
                        Flush_IF    = 1'b1;
                        w_clr       = 1'b1;
                        w_state_nxt = ST_RUN;
                        if (Br_Taken) begin
                            Pc_Next = Br_Target;
                        end else if (w_pend_valid) begin
                            Pc_Next = w_pend_target;
                        end
                    end
                end
                default: begin
                    w_state_nxt = c_RST_ST;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_boot_cnt <= c_BW'(BOOT_WAIT);
        end else if (r_state == ST_BOOT && r_boot_cnt > c_BW'(1)) begin
            r_boot_cnt <= r_boot_cnt - c_BW'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_fetch_valid <= 1'b0;
        end else if (w_state_nxt != ST_BOOT) begin
            r_fetch_valid <= 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_stall_cnt <= '0;
        end else if (r_state != ST_BOOT && !Pc_En && r_stall_cnt != '1) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign Fetch_Valid = r_fetch_valid;
    assign Stall_Cnt   = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pc_write_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pc_write_ctrl                                                   |
// | Directed self-checking bench for pc_write_ctrl.                    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_pc_write_ctrl;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] Pc_Cur;
    logic        Stall;
    logic        Br_Taken;
    logic [31:0] Br_Target;
    logic        Jmp;
    logic [31:0] Jmp_Target;
    logic [31:0] Pc_Next;
    logic        Pc_En;
    logic        Flush_IF;
    logic        Fetch_Valid;
    logic [3:0]  Stall_Cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clk = ~Clk;

    pc_write_ctrl #(
        .WIDTH       (32),
        .INSTR_BYTES (4),
        .BOOT_WAIT   (2),
        .CNT_W       (4)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .Pc_Cur      (Pc_Cur),
        .Stall       (Stall),
        .Br_Taken    (Br_Taken),
        .Br_Target   (Br_Target),
        .Jmp         (Jmp),
        .Jmp_Target  (Jmp_Target),
        .Pc_Next     (Pc_Next),
        .Pc_En       (Pc_En),
        .Flush_IF    (Flush_IF),
        .Fetch_Valid (Fetch_Valid),
        .Stall_Cnt   (Stall_Cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Apply inputs just after a rising edge, then settle to the falling edge.
    task automatic drive(input logic st, input logic br, input logic [31:0] bt,
                         input logic jp, input logic [31:0] jt, input logic [31:0] pc);
        Stall      = st;
        Br_Taken   = br;
        Br_Target  = bt;
        Jmp        = jp;
        Jmp_Target = jt;
        Pc_Cur     = pc;
        @(negedge Clk);
    endtask

    task automatic adv();
        @(posedge Clk);
        #1;
    endtask

    task automatic exp_pc(input string tag, input logic en, input logic fl, input logic [31:0] nxt);
        check_val({tag, ".en"},    {31'd0, Pc_En},    {31'd0, en});
        check_val({tag, ".flush"}, {31'd0, Flush_IF}, {31'd0, fl});
        if (en) check_val({tag, ".next"}, Pc_Next, nxt);
    endtask

    task automatic exp_regs(input string tag, input logic fv, input logic [3:0] sc);
        check_val({tag, ".fv"},  {31'd0, Fetch_Valid}, {31'd0, fv});
        check_val({tag, ".cnt"}, {28'd0, Stall_Cnt},   {28'd0, sc});
    endtask

    initial begin
        Rst = 1'b1;
        Stall = 0; Br_Taken = 0; Br_Target = 0; Jmp = 0; Jmp_Target = 0; Pc_Cur = 0;
        adv();
        // Reset overrides a redirect request.
        drive(0, 1, 32'h500, 1, 32'h600, 32'h0);
        exp_pc("rst", 0, 0, 32'h0);
        exp_regs("rst", 0, 4'd0);
        adv();
        Rst = 1'b0;

        // Boot wait of two cycles; stall during boot is ignored.
        drive(0, 0, 0, 0, 0, 32'h0);
        exp_pc("boot1", 0, 0, 32'h0);
        exp_regs("boot1", 0, 4'd0);
        adv();
        drive(1, 0, 0, 1, 32'h44, 32'h0);
        exp_pc("boot2", 0, 0, 32'h0);
        exp_regs("boot2", 0, 4'd0);
        adv();
        drive(0, 0, 0, 0, 0, 32'h0);
        exp_pc("run1", 1, 0, 32'h4);
        exp_regs("run1", 1, 4'd0);
        adv();

        // Branch beats a simultaneous jump.
        drive(0, 1, 32'h200, 1, 32'h300, 32'h100);
        exp_pc("br_jmp", 1, 1, 32'h200);
        adv();
        drive(0, 0, 0, 1, 32'h300, 32'h200);
        exp_pc("jmp", 1, 1, 32'h300);
        adv();
        drive(0, 0, 0, 0, 0, 32'hFFFF_FFFC);
        exp_pc("wrap", 1, 0, 32'h0);
        adv();

        // Jump latched under a 3-cycle stall.
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 1, 32'h40, 32'h10);
            exp_pc("stall_jmp", 0, 0, 32'h0);
            adv();
        end
        drive(0, 0, 0, 0, 0, 32'h10);
        exp_pc("hold_rel", 1, 1, 32'h40);
        exp_regs("hold_rel", 1, 4'd3);
        adv();
        drive(0, 0, 0, 0, 0, 32'h40);
        exp_pc("after_rel", 1, 0, 32'h44);
        adv();

        // Pending branch is not replaced by a later jump.
        drive(1, 1, 32'h80, 0, 0, 32'h44);
        exp_pc("st_br", 0, 0, 32'h0);
        adv();
        drive(1, 0, 0, 1, 32'h90, 32'h44);
        adv();
        drive(0, 0, 0, 0, 0, 32'h44);
        exp_pc("br_kept", 1, 1, 32'h80);
        exp_regs("br_kept", 1, 4'd5);
        adv();

        // Pending jump replaced by jump; fresh branch wins at release.
        drive(1, 0, 0, 1, 32'h50, 32'h80);
        adv();
        drive(1, 0, 0, 1, 32'h60, 32'h80);
        adv();
        drive(0, 1, 32'hA0, 0, 0, 32'h80);
        exp_pc("new_br_wins", 1, 1, 32'hA0);
        adv();

        // Pending jump replaced by branch; fresh jump ignored at release.
        drive(1, 0, 0, 1, 32'h70, 32'hA0);
        adv();
        drive(1, 1, 32'hB0, 0, 0, 32'hA0);
        adv();
        drive(0, 0, 0, 1, 32'hC0, 32'hA0);
        exp_pc("br_over_jmp", 1, 1, 32'hB0);
        exp_regs("br_over_jmp", 1, 4'd9);
        adv();

        // Plain stall with no redirect leaves nothing pending.
        drive(1, 0, 0, 0, 0, 32'hB0);
        exp_pc("plain_stall", 0, 0, 32'h0);
        adv();
        drive(0, 0, 0, 0, 0, 32'hB0);
        exp_pc("plain_rel", 1, 0, 32'hB4);
        exp_regs("plain_rel", 1, 4'd10);
        adv();

        // Stall counter saturates.
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 0, 0, 0, 32'hB4);
            adv();
        end
        drive(0, 0, 0, 0, 0, 32'hB4);
        exp_pc("sat_rel", 1, 0, 32'hB8);
        exp_regs("sat", 1, 4'd15);
        adv();

        // Reset in HOLD drops the pending branch.
        drive(1, 1, 32'hD0, 0, 0, 32'hB8);
        adv();
        Rst = 1'b1;
        drive(0, 0, 0, 0, 0, 32'hB8);
        exp_pc("rst_hold", 0, 0, 32'h0);
        adv();
        Rst = 1'b0;
        drive(0, 0, 0, 0, 0, 32'h10);
        exp_pc("reboot1", 0, 0, 32'h0);
        exp_regs("reboot1", 0, 4'd0);
        adv();
        drive(0, 0, 0, 0, 0, 32'h10);
        exp_pc("reboot2", 0, 0, 32'h0);
        adv();
        drive(0, 0, 0, 0, 0, 32'h10);
        exp_pc("rerun", 1, 0, 32'h14);
        exp_regs("rerun", 1, 4'd0);
        adv();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
